// File: rtl/clk_param_meter.sv
// clk_param_meter: recovers start phase, high/low time and period of an async
// periodic input in clk cycles, and flags an input that stopped toggling.
// Ports: clk, rst (sync, active high), sig_in (async waveform);
//   phase_o/phase_valid_o  low+high prefix before first rise, sticky valid
//   ton_o/toff_o/period_o  last complete period, meas_valid_o one-cycle pulse
//   sat_o                  a published field hit 2^WIDTH-1
//   stuck_o/stuck_lvl_o    no transition for TIMEOUT samples, held level
//   nper_o                 completed periods since reset (wraps)
module clk_param_meter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] phase_o,
  output logic [WIDTH-1:0] ton_o,
  output logic [WIDTH-1:0] toff_o,
  output logic [WIDTH:0]   period_o,
  output logic             meas_valid_o,
  output logic             phase_valid_o,
  output logic             sat_o,
  output logic             stuck_o,
  output logic             stuck_lvl_o,
  output logic [15:0]      nper_o
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] TOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_inc(
    input logic [WIDTH-1:0] v
  );
    return (v == MAXV) ? v : v + ONE;
  endfunction

  state_e             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               cur_q, cur_d;
  logic               prev_q, prev_d;
  logic [2:0]         warm_q, warm_d;
  logic [WIDTH-1:0]   ph_cnt_q, ph_cnt_d;
  logic [WIDTH-1:0]   ton_cnt_q, ton_cnt_d;
  logic [WIDTH-1:0]   ton_lat_q, ton_lat_d;
  logic [WIDTH-1:0]   toff_cnt_q, toff_cnt_d;
  logic [WIDTH-1:0]   idle_q, idle_d;
  logic [WIDTH-1:0]   phase_q, phase_d;
  logic               phase_vld_q, phase_vld_d;
  logic [WIDTH-1:0]   ton_q, ton_d;
  logic [WIDTH-1:0]   toff_q, toff_d;
  logic [WIDTH:0]     period_q, period_d;
  logic               meas_vld_q, meas_vld_d;
  logic               sat_q, sat_d;
  logic               stuck_q, stuck_d;
  logic               stuck_lvl_q, stuck_lvl_d;
  logic [15:0]        nper_q, nper_d;

  logic               rise;
  logic               fall;
  logic               act;
  logic [WIDTH-1:0]   idle_inc;

  // cur/prev hold samples x[n] and x[n-1]; the pipeline
  // resets to 1 so a high input at release is not a rise.
  assign rise     = cur_q & ~prev_q;
  assign fall     = ~cur_q & prev_q;
  // warm-up: ignore the reset-filled pipeline slots
  assign act      = warm_q[2];
  assign idle_inc = (idle_q == TOUT) ? idle_q : idle_q + ONE;

  always_comb begin
    state_d     = state_q;
    sync1_d     = sig_in;
    sync2_d     = sync1_q;
    cur_d       = sync2_q;
    prev_d      = cur_q;
    warm_d      = {warm_q[1:0], 1'b1};
    ph_cnt_d    = ph_cnt_q;
    ton_cnt_d   = ton_cnt_q;
    ton_lat_d   = ton_lat_q;
    toff_cnt_d  = toff_cnt_q;
    idle_d      = idle_q;
    phase_d     = phase_q;
    phase_vld_d = phase_vld_q;
    ton_d       = ton_q;
    toff_d      = toff_q;
    period_d    = period_q;
    meas_vld_d  = 1'b0;
    sat_d       = sat_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    nper_d      = nper_q;

    if (act) begin
      // a transition always beats a coincident timeout
      if (rise || fall) begin
        idle_d      = '0;
        stuck_d     = 1'b0;
        stuck_lvl_d = 1'b0;
      end else begin
        idle_d = idle_inc;
        if (idle_inc == TOUT) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = cur_q;
        end
      end

      unique case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            phase_d     = ph_cnt_q;
            phase_vld_d = 1'b1;
            ton_cnt_d   = ONE;
            state_d     = HIGH;
          end else begin
            ph_cnt_d = sat_inc(ph_cnt_q);
          end
        end
        HIGH: begin
          if (fall) begin
            ton_lat_d  = ton_cnt_q;
            toff_cnt_d = ONE;
            state_d    = LOW;
          end else begin
            ton_cnt_d = sat_inc(ton_cnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            ton_d      = ton_lat_q;
            toff_d     = toff_cnt_q;
            period_d   = {1'b0, ton_lat_q} + {1'b0, toff_cnt_q};
            sat_d      = (ton_lat_q == MAXV) || (toff_cnt_q == MAXV);
            meas_vld_d = 1'b1;
            nper_d     = nper_q + 16'd1;
            ton_cnt_d  = ONE;
            state_d    = HIGH;
          end else begin
            toff_cnt_d = sat_inc(toff_cnt_q);
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_RISE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cur_q       <= 1'b1;
      prev_q      <= 1'b1;
      warm_q      <= '0;
      ph_cnt_q    <= '0;
      ton_cnt_q   <= '0;
      ton_lat_q   <= '0;
      toff_cnt_q  <= '0;
      idle_q      <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      ton_q       <= '0;
      toff_q      <= '0;
      period_q    <= '0;
      meas_vld_q  <= 1'b0;
      sat_q       <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      nper_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      warm_q      <= warm_d;
      ph_cnt_q    <= ph_cnt_d;
      ton_cnt_q   <= ton_cnt_d;
      ton_lat_q   <= ton_lat_d;
      toff_cnt_q  <= toff_cnt_d;
      idle_q      <= idle_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      ton_q       <= ton_d;
      toff_q      <= toff_d;
      period_q    <= period_d;
      meas_vld_q  <= meas_vld_d;
      sat_q       <= sat_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      nper_q      <= nper_d;
    end
  end

  assign phase_o       = phase_q;
  assign phase_valid_o = phase_vld_q;
  assign ton_o         = ton_q;
  assign toff_o        = toff_q;
  assign period_o      = period_q;
  assign meas_valid_o  = meas_vld_q;
  assign sat_o         = sat_q;
  assign stuck_o       = stuck_q;
  assign stuck_lvl_o   = stuck_lvl_q;
  assign nper_o        = nper_q;

endmodule

// File: tb/tb_clk_param_meter.sv
// tb_clk_param_meter: directed bench for clk_param_meter
// (WIDTH=16/TIMEOUT=1000 main instance, WIDTH=4/TIMEOUT=15 saturation one).
module tb_clk_param_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] phase_o, ton_o, toff_o, nper_o;
  logic [16:0] period_o;
  logic        meas_valid_o, phase_valid_o, sat_o;
  logic        stuck_o, stuck_lvl_o;

  logic [3:0]  ph4, ton4, toff4;
  logic [4:0]  per4;
  logic        mv4, pv4, sat4, st4, sl4;
  logic [15:0] np4;

  clk_param_meter #(.WIDTH(16), .TIMEOUT(1000)) dut (
    .clk           (clk),
    .rst           (rst),
    .sig_in        (sig),
    .phase_o       (phase_o),
    .ton_o         (ton_o),
    .toff_o        (toff_o),
    .period_o      (period_o),
    .meas_valid_o  (meas_valid_o),
    .phase_valid_o (phase_valid_o),
    .sat_o         (sat_o),
    .stuck_o       (stuck_o),
    .stuck_lvl_o   (stuck_lvl_o),
    .nper_o        (nper_o)
  );

  clk_param_meter #(.WIDTH(4), .TIMEOUT(15)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .sig_in        (sig),
    .phase_o       (ph4),
    .ton_o         (ton4),
    .toff_o        (toff4),
    .period_o      (per4),
    .meas_valid_o  (mv4),
    .phase_valid_o (pv4),
    .sat_o         (sat4),
    .stuck_o       (st4),
    .stuck_lvl_o   (sl4),
    .nper_o        (np4)
  );

  typedef struct {
    int          e;
    logic [15:0] ton;
    logic [15:0] toff;
    logic [16:0] per;
    logic        sat;
    logic [15:0] np;
  } pulse_t;

  pulse_t pq[$];
  int     n;
  int     pv_edge;
  int     st_edge;
  int     checks;
  int     errors;

  // record publications, first phase_valid and first stuck
  always @(negedge clk) begin
    pulse_t p;
    if (rst) begin
      pq.delete();
      pv_edge = 0;
      st_edge = 0;
    end else begin
      if (meas_valid_o) begin
        p.e    = n;
        p.ton  = ton_o;
        p.toff = toff_o;
        p.per  = period_o;
        p.sat  = sat_o;
        p.np   = nper_o;
        pq.push_back(p);
      end
      if (phase_valid_o && pv_edge == 0) pv_edge = n;
      if (stuck_o && st_edge == 0) st_edge = n;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic lvl);
    sig = lvl;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic hold(input logic lvl, input int cnt);
    for (int i = 0; i < cnt; i++) step(lvl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
  endtask

  task automatic chk_pulse(input int i, input int e,
                           input int ton, input int toff,
                           input int np, input int sat);
    if (i >= pq.size()) begin
      chk($sformatf("pulse%0d_present", i), 32'(pq.size()), 32'(i + 1));
    end else begin
      chk($sformatf("p%0d_edge", i), 32'(pq[i].e), 32'(e));
      chk($sformatf("p%0d_ton", i), 32'(pq[i].ton), 32'(ton));
      chk($sformatf("p%0d_toff", i), 32'(pq[i].toff), 32'(toff));
      chk($sformatf("p%0d_per", i), 32'(pq[i].per), 32'(ton + toff));
      chk($sformatf("p%0d_sat", i), 32'(pq[i].sat), 32'(sat));
      chk($sformatf("p%0d_nper", i), 32'(pq[i].np), 32'(np));
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_phase"}, 32'(phase_o), 0);
    chk({pfx, "_pv"}, 32'(phase_valid_o), 0);
    chk({pfx, "_ton"}, 32'(ton_o), 0);
    chk({pfx, "_toff"}, 32'(toff_o), 0);
    chk({pfx, "_per"}, 32'(period_o), 0);
    chk({pfx, "_mv"}, 32'(meas_valid_o), 0);
    chk({pfx, "_sat"}, 32'(sat_o), 0);
    chk({pfx, "_stuck"}, 32'(stuck_o), 0);
    chk({pfx, "_slvl"}, 32'(stuck_lvl_o), 0);
    chk({pfx, "_nper"}, 32'(nper_o), 0);
  endtask

  initial begin
    n      = 0;
    checks = 0;
    errors = 0;

    // phase / duty 5:5
    do_reset();
    chk_zero("rst");
    hold(1'b0, 7);
    for (int r = 0; r < 4; r++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    chk("t1_phase", 32'(phase_o), 7);
    chk("t1_pv", 32'(phase_valid_o), 1);
    chk("t1_pv_edge", 32'(pv_edge), 11);
    chk("t1_npulse", 32'(pq.size()), 3);
    for (int i = 0; i < 3; i++) chk_pulse(i, 21 + 10 * i, 5, 5, i + 1, 0);

    // stuck low after fall at sample 43
    hold(1'b0, 1100 - 47);
    chk("st_edge", 32'(st_edge), 1046);
    chk("st_set", 32'(stuck_o), 1);
    chk("st_lvl", 32'(stuck_lvl_o), 0);
    hold(1'b1, 3);
    chk("st_hold", 32'(stuck_o), 1);
    chk("st_mv_early", 32'(meas_valid_o), 0);
    step(1'b1);
    chk("st_clear", 32'(stuck_o), 0);
    chk("st_mv", 32'(meas_valid_o), 1);
    chk("st_ton", 32'(ton_o), 5);
    chk("st_toff", 32'(toff_o), 1058);
    chk("st_per", 32'(period_o), 1063);
    chk("st_sat", 32'(sat_o), 0);
    chk("st_nper", 32'(nper_o), 4);

    // high at reset, then 2:6, then 1:1
    do_reset();
    hold(1'b1, 4);
    hold(1'b0, 3);
    for (int r = 0; r < 3; r++) begin
      hold(1'b1, 2);
      hold(1'b0, 6);
    end
    chk("t2_phase", 32'(phase_o), 7);
    chk("t2_pv_edge", 32'(pv_edge), 11);
    chk("t2_npulse", 32'(pq.size()), 2);
    chk_pulse(0, 19, 2, 6, 1, 0);
    chk_pulse(1, 27, 2, 6, 2, 0);
    for (int r = 0; r < 6; r++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 4);
    chk("t3_npulse", 32'(pq.size()), 8);
    chk_pulse(2, 35, 2, 6, 3, 0);
    for (int i = 0; i < 5; i++) chk_pulse(3 + i, 37 + 2 * i, 1, 1, 4 + i, 0);

    // saturation on the WIDTH=4 instance
    do_reset();
    hold(1'b0, 2);
    hold(1'b1, 20);
    hold(1'b0, 3);
    hold(1'b1, 3);
    chk("s4_mv_early", 32'(mv4), 0);
    step(1'b1);
    chk("s4_mv", 32'(mv4), 1);
    chk("s4_ton", 32'(ton4), 15);
    chk("s4_toff", 32'(toff4), 3);
    chk("s4_per", 32'(per4), 18);
    chk("s4_sat", 32'(sat4), 1);
    chk("s4_phase", 32'(ph4), 2);
    chk("s4_pv", 32'(pv4), 1);
    hold(1'b1, 1);
    hold(1'b0, 5);
    hold(1'b1, 4);
    chk("s4b_mv", 32'(mv4), 1);
    chk("s4b_ton", 32'(ton4), 5);
    chk("s4b_toff", 32'(toff4), 5);
    chk("s4b_per", 32'(per4), 10);
    chk("s4b_sat", 32'(sat4), 0);
    chk("s4b_nper", 32'(np4), 2);

    // reset during a HIGH run
    rst = 1'b1;
    step(1'b1);
    chk_zero("mrst");
    chk("mrst_mv4", 32'(mv4), 0);
    chk("mrst_pv4", 32'(pv4), 0);
    rst = 1'b0;
    n   = 0;
    hold(1'b0, 3);
    hold(1'b1, 6);
    chk("mrst_phase", 32'(phase_o), 3);
    chk("mrst_pv_edge", 32'(pv_edge), 7);
    chk("mrst_npulse", 32'(pq.size()), 0);
    chk("mrst_nper", 32'(nper_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
